// File: rtl/sound_in_pkg.sv
// Register map and bit positions shared by the sound capture slave.
package sound_in_pkg;
  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVF       = 2;
  localparam int unsigned ST_LEVEL_LSB = 8;

  localparam int unsigned CTL_CLR_OVF = 0;
  localparam int unsigned CTL_FLUSH   = 1;
endpackage

// File: rtl/sound_in_fifo.sv
// Single-clock sample FIFO; flush beats push/pop, and a pop frees room for a push in the same cycle.
module sound_in_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end
endmodule

// File: rtl/nios_system_sound_in.sv
// Avalon-MM capture slave: register decode, sticky overflow, irq mask and registered irq.
module nios_system_sound_in
  import sound_in_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  input  logic [15:0] in_port,
  input  logic        in_valid,
  output logic [31:0] readdata,
  output logic        irq
);
  logic [15:0]   head;
  logic [LW-1:0] level;
  logic          empty, full;
  logic          overflow;
  logic [1:0]    irqmask;
  logic          pop_req, wr_en, flush, clr_ovf, ovf_set;
  logic          unused_wdata;

  assign pop_req      = chipselect & ~read_n & (address == ADDR_DATA);
  assign wr_en        = chipselect & ~write_n;
  assign flush        = wr_en & (address == ADDR_CONTROL) & writedata[CTL_FLUSH];
  assign clr_ovf      = wr_en & (address == ADDR_CONTROL) & writedata[CTL_CLR_OVF];
  // A pop in the same cycle makes room, so a full FIFO only overflows without one.
  assign ovf_set      = in_valid & full & ~pop_req;
  assign unused_wdata = ^writedata[31:2];

  sound_in_fifo #(.DEPTH(DEPTH), .W(16)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (pop_req),
    .flush   (flush),
    .din     (in_port),
    .head    (head),
    .level   (level),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      irqmask  <= 2'b00;
      irq      <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (wr_en && address == ADDR_IRQMASK) irqmask <= writedata[1:0];
      irq <= (irqmask[0] & ~empty) | (irqmask[1] & overflow);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    if (!empty) readdata[15:0] = head;
      ADDR_STATUS: begin
        readdata[ST_EMPTY]              = empty;
        readdata[ST_FULL]               = full;
        readdata[ST_OVF]                = overflow;
        readdata[ST_LEVEL_LSB +: LW]    = level;
      end
      ADDR_IRQMASK: readdata[1:0] = irqmask;
      default:      readdata = '0;
    endcase
  end
endmodule

// File: tb/tb_nios_system_sound_in.sv
// Scoreboard bench: stimulus queues expected read/irq values, a negedge monitor compares.
module tb_nios_system_sound_in;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [15:0] in_port = '0;
  logic        in_valid = 1'b0;
  logic [31:0] readdata;
  logic        irq;
  logic        irq_chk = 1'b0;

  typedef struct packed {
    logic [1:0]  addr;
    logic [31:0] val;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  logic    irq_q[$];
  int      vectors = 0;
  int      errors  = 0;

  nios_system_sound_in #(.DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .in_valid   (in_valid),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chipselect && !read_n) begin
      vectors++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_underflow: read at addr %0d with no expected value", address);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if (address !== e.addr || readdata !== e.val) begin
          errors++;
          $display("FAIL rd_addr%0d: got 0x%08h (addr %0d), expected 0x%08h", e.addr, readdata, address, e.val);
        end
      end
    end
    if (irq_chk) begin
      vectors++;
      if (irq_q.size() == 0) begin
        errors++;
        $display("FAIL irq_underflow: irq check with no expected value");
      end else begin
        logic ei;
        ei = irq_q.pop_front();
        if (irq !== ei) begin
          errors++;
          $display("FAIL irq: got %b, expected %b", irq, ei);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] s);
    in_port  = s;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    rd_q.push_back('{addr: a, val: exp});
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    tick();
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_irq(input logic e);
    irq_q.push_back(e);
    irq_chk = 1'b1;
    tick();
    irq_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked while held in reset and after release
    tick();
    rd(2'd1, 32'h1);
    chk_irq(1'b0);
    reset_n = 1'b1;
    tick();
    rd(2'd1, 32'h1);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h1);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    chk_irq(1'b0);

    // Basic ordering
    push(16'h1111); push(16'h2222); push(16'h3333);
    rd(2'd1, 32'h0000_0300);
    rd(2'd0, 32'h1111); rd(2'd0, 32'h2222); rd(2'd0, 32'h3333);
    rd(2'd1, 32'h1);

    // Overflow with 9 pushes; the 9th is dropped
    for (int i = 0; i < 9; i++) push(16'hA000 + 16'(i));
    rd(2'd1, 32'h0000_0806);
    for (int i = 0; i < 8; i++) rd(2'd0, 32'h0000_A000 + 32'(i));
    rd(2'd1, 32'h5);
    wr(2'd3, 32'h1);
    rd(2'd1, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd1, 32'h1);

    // Full FIFO with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 8; i++) push(16'hB000 + 16'(i));
    in_port  = 16'hB008;
    in_valid = 1'b1;
    rd(2'd0, 32'h0000_B000);
    in_valid = 1'b0;
    rd(2'd1, 32'h0000_0802);
    for (int i = 1; i < 9; i++) rd(2'd0, 32'h0000_B000 + 32'(i));
    rd(2'd1, 32'h1);

    // Not-empty interrupt
    wr(2'd2, 32'hFFFF_FFFD);
    rd(2'd2, 32'h1);
    push(16'hC001);
    chk_irq(1'b0);
    chk_irq(1'b1);
    rd(2'd0, 32'h0000_C001);
    chk_irq(1'b1);
    chk_irq(1'b0);

    // Overflow interrupt held until cleared
    wr(2'd2, 32'h2);
    for (int i = 0; i < 9; i++) push(16'hD000 + 16'(i));
    chk_irq(1'b0);
    chk_irq(1'b1);
    chk_irq(1'b1);
    wr(2'd3, 32'h1);
    chk_irq(1'b1);
    chk_irq(1'b0);
    rd(2'd1, 32'h0000_0802);
    rd(2'd0, 32'h0000_D000);

    // Flush in the same cycle as a push
    wr(2'd3, 32'h2);
    rd(2'd1, 32'h1);
    push(16'hE000); push(16'hE001); push(16'hE002);
    rd(2'd1, 32'h0000_0300);
    in_port  = 16'hE003;
    in_valid = 1'b1;
    wr(2'd3, 32'h2);
    in_valid = 1'b0;
    rd(2'd1, 32'h1);
    rd(2'd0, 32'h0);

    // Asynchronous reset mid-stream
    wr(2'd2, 32'h1);
    push(16'hF000); push(16'hF001);
    chk_irq(1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_irq: got %b, expected 0", irq);
    end
    tick();
    rd(2'd1, 32'h1);
    rd(2'd2, 32'h0);
    rd(2'd0, 32'h0);
    chk_irq(1'b0);
    reset_n = 1'b1;
    tick();
    rd(2'd1, 32'h1);
    chk_irq(1'b0);

    tick(); tick();
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d reads and %0d irq checks never observed", rd_q.size(), irq_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/nios_system_sound_in.md
# nios_system_sound_in

Avalon-MM slave that captures 16-bit audio samples from the codec-side capture path into a small FIFO for the Nios II CPU. It is the receive counterpart of the sound output PIO. Samples are pushed on a one-cycle valid strobe. The CPU pops them through a zero-wait-state data register and monitors level and overflow through a status register. An optional interrupt fires on FIFO not-empty or overflow.

## Interface
- DEPTH, 8, FIFO depth in samples; power of two, 2..128
- LW, $clog2(DEPTH)+1, level counter width (derived, not overridable)
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select: 0 DATA, 1 STATUS, 2 IRQMASK, 3 CONTROL
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  16  capture sample, qualified by in_valid
- in_valid  in  1  one-cycle push strobe, synchronous to clk
- readdata  out  32  combinational read data, zero wait states
- irq  out  1  level interrupt to CPU

## Operation
- Reset: FIFO empty, level 0, overflow 0, irqmask 0, irq 0, readdata reflects the reset register state.
- Push: on in_valid=1 with the FIFO not full, in_port is written at the write pointer, and wptr and level advance.
- Overflow: on in_valid=1 with the FIFO full and no pop in the same cycle, the sample is dropped, the overflow bit is set (sticky), and the FIFO is unchanged.
- Pop: on chipselect=1, read_n=0, address=0 with the FIFO not empty, rptr advances and level decrements at the clock edge.
- Pop while empty: readdata=0 and no state change.
- Simultaneous push+pop: both take effect and level is unchanged. This holds even when the FIFO is full, so no overflow is flagged.
- DATA (addr 0) read: {16'b0, head sample}. Returns 0 when empty.
- STATUS (addr 1) read: bit0 empty, bit1 full, bit2 overflow, bits[8+LW-1:8] level, all other bits 0.
- IRQMASK (addr 2):
  - Read/write bits[1:0]; other bits read 0.
  - bit0 enables the not-empty interrupt; bit1 enables the overflow interrupt.
- CONTROL (addr 3):
  - Write-only; reads return 0.
  - Writing bit0=1 clears overflow.
  - Writing bit1=1 flushes the FIFO: pointers and level go to 0.
  - A flush in the same cycle as a push wins, and the sample is discarded.
  - A push that overflows in the same cycle as an overflow-clear leaves overflow=1 (set wins).
- Writes to DATA and STATUS are ignored.
- irq = (mask[0] & ~empty) | (mask[1] & overflow), registered, so it asserts one cycle after the causing edge.
- Pointers wrap modulo DEPTH. Level runs 0..DEPTH and never wraps.

## Timing
- readdata is combinational from address and current state. The CPU samples it in the same cycle it asserts read_n, and the pop takes effect at that cycle's closing edge.
- Push-to-visible latency: a sample pushed at edge N is readable at DATA in cycle N+1. STATUS.empty drops at N+1 as well.
- irq latency: one cycle after the status change that causes it. irq deasserts one cycle after the cause clears.
- Reset asserted mid-operation clears everything immediately, including irq, regardless of clk. Sample storage contents need not be cleared.
- No back-pressure on in_valid. The producer is never stalled.

## Structure
- Shared package sound_in_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_IRQMASK=2, ADDR_CONTROL=3
  - STATUS bit positions (ST_EMPTY, ST_FULL, ST_OVF, ST_LEVEL_LSB=8)
  - CONTROL bit positions (CTL_CLR_OVF, CTL_FLUSH)
- One sub-module, sound_in_fifo: synchronous single-clock FIFO with push, pop and flush inputs, and head, level, empty and full outputs. It is parameterised by DEPTH and width 16. The top level holds the register decode, the overflow/irqmask registers, and the irq logic.

## Test plan
- Reset, then read STATUS: returns 0x00000001 (empty). DATA reads 0. irq=0.
- Push 0x1111, 0x2222, 0x3333, then read DATA three times: returns 0x1111, 0x2222, 0x3333 in order. STATUS is then 0x1 with level 0.
- Push 9 samples at DEPTH=8: STATUS = full, overflow, level 8 → 0x00000806. Reading DATA returns the first 8 samples, and the 9th is absent. Write CONTROL=0x1 clears overflow.
- Fill to full, then push and pop in the same cycle: overflow stays 0, level stays 8, and FIFO order is preserved across pointer wrap.
- IRQMASK=0x1, then push one sample: irq rises one cycle after the push edge. Popping it drops irq one cycle later. IRQMASK=0x2 plus an overflow keeps irq high until CONTROL=0x1 is written.
- With 3 samples queued, write CONTROL=0x2 in the same cycle as a push: level becomes 0 and empty=1. Assert reset_n=0 mid-stream and check every output is at its reset value.
